mmio_slot_ctrl: RTL and testbench

- Parametrised MMIO slot controller between the MicroBlaze MCS I/O bridge and the slot cores.
- Decodes the MMIO address into slot index and register offset, and issues a one-cycle strobe to the selected slot.
- Waits for a per-slot acknowledge and returns registered read data with a ready pulse.
- Unlike the fixed single-cycle decoder, it supports stalling slots, timeout with bus error, and out-of-range slot detection.

---
 rtl/mmio_slot_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_mmio_slot_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_slot_ctrl.sv
// rtl/mmio_slot_ctrl.sv - MMIO slot controller: address decode, slot strobe, ack wait, timeout and bus error
// Optional error log outputs (err_count, err_last_addr) are built when MMIO_SLOT_ERR_LOG_EN is defined.
module mmio_slot_ctrl #(
  parameter int          NUM_SLOTS       = 64,
  parameter int          SLOT_ADDR_WIDTH = 6,
  parameter int          REG_ADDR_WIDTH  = 5,
  parameter int          MMIO_ADDR_WIDTH = 21,
  parameter int          DATA_WIDTH      = 32,
  parameter int          TIMEOUT_CYCLES  = 16,
  parameter logic [31:0] ERR_PATTERN     = 32'hDEAD_BEEF
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            mmio_cs,
  input  logic                            mmio_wr,
  input  logic                            mmio_rd,
  input  logic [MMIO_ADDR_WIDTH-1:0]      mmio_addr,
  input  logic [DATA_WIDTH-1:0]           mmio_wr_data,
  output logic [DATA_WIDTH-1:0]           mmio_rd_data,
  output logic                            mmio_ready,
  output logic                            mmio_err,
  output logic                            mmio_busy,
  output logic [NUM_SLOTS-1:0]            slot_cs_array,
  output logic [NUM_SLOTS-1:0]            slot_mem_wr_array,
  output logic [NUM_SLOTS-1:0]            slot_mem_rd_array,
  output logic [REG_ADDR_WIDTH-1:0]       slot_reg_addr,
  output logic [DATA_WIDTH-1:0]           slot_wr_data,
  input  logic [NUM_SLOTS*DATA_WIDTH-1:0] slot_rd_data_array,
  input  logic [NUM_SLOTS-1:0]            slot_ack_array
`ifdef MMIO_SLOT_ERR_LOG_EN
  ,
  output logic [15:0]                     err_count,
  output logic [SLOT_ADDR_WIDTH+REG_ADDR_WIDTH-1:0] err_last_addr
`endif
);

  localparam int ADDR_W = SLOT_ADDR_WIDTH + REG_ADDR_WIDTH;
  localparam int CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]           CNT_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [SLOT_ADDR_WIDTH:0]   NUM_SLOTS_W = (SLOT_ADDR_WIDTH + 1)'(NUM_SLOTS);
  localparam logic [DATA_WIDTH-1:0]      ERR_DATA    = DATA_WIDTH'(ERR_PATTERN);

  typedef enum logic [1:0] {IDLE, STROBE, WAIT, DONE} state_t;

  state_t                     state;
  logic [NUM_SLOTS-1:0]       sel_q;
  logic [SLOT_ADDR_WIDTH-1:0] slot_q;
  logic                       rd_q;
  logic [CNT_W-1:0]           cnt;

  logic [SLOT_ADDR_WIDTH-1:0] req_slot;
  logic [REG_ADDR_WIDTH-1:0]  req_reg;
  logic                       req_valid;
  logic                       req_bad;
  logic [NUM_SLOTS-1:0]       req_onehot;
  logic                       ack_hit;
  logic [DATA_WIDTH-1:0]      sel_data;
  logic [DATA_WIDTH-1:0]      ok_data;
  logic [DATA_WIDTH-1:0]      fail_data;

  assign req_slot   = mmio_addr[ADDR_W-1:REG_ADDR_WIDTH];
  assign req_reg    = mmio_addr[REG_ADDR_WIDTH-1:0];
  assign req_valid  = mmio_cs & (mmio_rd | mmio_wr);
  assign req_bad    = (mmio_rd & mmio_wr) | ({1'b0, req_slot} >= NUM_SLOTS_W);
  // Out-of-range slots shift the single bit off the top, giving an all-zero vector.
  assign req_onehot = NUM_SLOTS'(1) << req_slot;
  // Only the latched slot's ack counts; everyone else's is masked off.
  assign ack_hit    = |(slot_ack_array & sel_q);
  assign ok_data    = rd_q ? sel_data : '0;
  assign fail_data  = rd_q ? ERR_DATA : '0;

  // Read-data mux driven by the latched one-hot select.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (sel_q[i]) begin
        sel_data = sel_data | slot_rd_data_array[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Transaction FSM; every bus-facing output is registered here.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state             <= IDLE;
      sel_q             <= '0;
      slot_q            <= '0;
      rd_q              <= 1'b0;
      cnt               <= '0;
      mmio_rd_data      <= '0;
      mmio_ready        <= 1'b0;
      mmio_err          <= 1'b0;
      mmio_busy         <= 1'b0;
      slot_cs_array     <= '0;
      slot_mem_wr_array <= '0;
      slot_mem_rd_array <= '0;
      slot_reg_addr     <= '0;
      slot_wr_data      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            mmio_busy     <= 1'b1;
            slot_q        <= req_slot;
            slot_reg_addr <= req_reg;
            slot_wr_data  <= mmio_wr_data;
            rd_q          <= mmio_rd;
            cnt           <= '0;
            if (req_bad) begin
              sel_q        <= '0;
              state        <= DONE;
              mmio_ready   <= 1'b1;
              mmio_err     <= 1'b1;
              mmio_rd_data <= mmio_rd ? ERR_DATA : '0;
            end else begin
              sel_q             <= req_onehot;
              slot_cs_array     <= req_onehot;
              slot_mem_wr_array <= mmio_wr ? req_onehot : '0;
              slot_mem_rd_array <= mmio_rd ? req_onehot : '0;
              state             <= STROBE;
            end
          end
        end
        STROBE: begin
          slot_cs_array     <= '0;
          slot_mem_wr_array <= '0;
          slot_mem_rd_array <= '0;
          cnt               <= cnt + 1'b1;
          if (ack_hit) begin
            state        <= DONE;
            mmio_ready   <= 1'b1;
            mmio_err     <= 1'b0;
            mmio_rd_data <= ok_data;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (ack_hit) begin
            state        <= DONE;
            mmio_ready   <= 1'b1;
            mmio_err     <= 1'b0;
            mmio_rd_data <= ok_data;
          end else if (cnt == CNT_LAST) begin
            state        <= DONE;
            mmio_ready   <= 1'b1;
            mmio_err     <= 1'b1;
            mmio_rd_data <= fail_data;
          end
        end
        DONE: begin
          mmio_ready <= 1'b0;
          mmio_err   <= 1'b0;
          mmio_busy  <= 1'b0;
          sel_q      <= '0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MMIO_SLOT_ERR_LOG_EN
  // Saturating error counter and address of the latest failed access.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      err_count     <= '0;
      err_last_addr <= '0;
    end else if (state == DONE && mmio_err) begin
      if (err_count != 16'hFFFF) begin
        err_count <= err_count + 16'd1;
      end
      err_last_addr <= {slot_q, slot_reg_addr};
    end
  end
`else
  logic unused_slot;
  assign unused_slot = ^slot_q;
`endif

  generate
    if (MMIO_ADDR_WIDTH > ADDR_W) begin : g_upper
      logic unused_upper;
      assign unused_upper = ^mmio_addr[MMIO_ADDR_WIDTH-1:ADDR_W];
    end
  endgenerate

endmodule

// File: tb/tb_mmio_slot_ctrl.sv
// tb/tb_mmio_slot_ctrl.sv - vector table and scoreboard bench for mmio_slot_ctrl
module tb_mmio_slot_ctrl;

  localparam int NS  = 4;
  localparam int SAW = 6;
  localparam int RAW = 5;
  localparam int MAW = 21;
  localparam int DW  = 32;
  localparam int TO  = 16;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             mmio_cs, mmio_wr, mmio_rd;
  logic [MAW-1:0]   mmio_addr;
  logic [DW-1:0]    mmio_wr_data;
  logic [DW-1:0]    mmio_rd_data;
  logic             mmio_ready, mmio_err, mmio_busy;
  logic [NS-1:0]    slot_cs_array, slot_mem_wr_array, slot_mem_rd_array;
  logic [RAW-1:0]   slot_reg_addr;
  logic [DW-1:0]    slot_wr_data;
  logic [NS*DW-1:0] slot_rd_data_array;
  logic [NS-1:0]    slot_ack_array;
`ifdef MMIO_SLOT_ERR_LOG_EN
  logic [15:0]      err_count;
  logic [SAW+RAW-1:0] err_last_addr;
`endif

  always #5 clk = ~clk;

  mmio_slot_ctrl #(
    .NUM_SLOTS(NS), .SLOT_ADDR_WIDTH(SAW), .REG_ADDR_WIDTH(RAW),
    .MMIO_ADDR_WIDTH(MAW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO),
    .ERR_PATTERN(32'hDEAD_BEEF)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .mmio_cs(mmio_cs), .mmio_wr(mmio_wr), .mmio_rd(mmio_rd),
    .mmio_addr(mmio_addr), .mmio_wr_data(mmio_wr_data),
    .mmio_rd_data(mmio_rd_data), .mmio_ready(mmio_ready),
    .mmio_err(mmio_err), .mmio_busy(mmio_busy),
    .slot_cs_array(slot_cs_array), .slot_mem_wr_array(slot_mem_wr_array),
    .slot_mem_rd_array(slot_mem_rd_array), .slot_reg_addr(slot_reg_addr),
    .slot_wr_data(slot_wr_data), .slot_rd_data_array(slot_rd_data_array),
    .slot_ack_array(slot_ack_array)
`ifdef MMIO_SLOT_ERR_LOG_EN
    , .err_count(err_count), .err_last_addr(err_last_addr)
`endif
  );

  typedef struct {
    logic        wr;
    logic        rd;
    int          slot;
    int          regn;
    logic [31:0] wdata;
    int          ack_dly;
    logic [31:0] ack_data;
    logic        exp_err;
    logic        chk_rd;
    logic [31:0] exp_rd;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic        err;
    logic        chk_rd;
    logic [31:0] rd;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[10];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int id, input vec_t v, input bit busy_req, input bit spur);
    logic [NS-1:0] oh;
    bit            bad;
    int            lat;
    int            readies;
    exp_t          e;
    bad = (v.slot >= NS) || (v.rd && v.wr);
    oh  = bad ? '0 : (NS'(1) << v.slot);
    @(negedge clk);
    mmio_cs   = 1'b1;
    mmio_rd   = v.rd;
    mmio_wr   = v.wr;
    mmio_addr = MAW'($urandom);
    mmio_addr[SAW+RAW-1:0] = {v.slot[SAW-1:0], v.regn[RAW-1:0]};
    mmio_wr_data = v.wdata;
    for (int i = 0; i < NS; i++) slot_rd_data_array[i*DW +: DW] = 32'hB0B0_0000 | i;
    if (!bad) slot_rd_data_array[v.slot*DW +: DW] = v.ack_data;
    e.err = v.exp_err; e.chk_rd = v.chk_rd; e.rd = v.exp_rd;
    sb.push_back(e);
    @(posedge clk); #1;
    if (busy_req) begin
      mmio_cs = 1'b1; mmio_wr = 1'b1; mmio_rd = 1'b0;
      mmio_addr[SAW+RAW-1:0] = {6'd1, 5'd0};
      mmio_wr_data = 32'h7777_7777;
    end else begin
      mmio_cs = 1'b0; mmio_wr = 1'b0; mmio_rd = 1'b0;
    end
    lat = 0;
    readies = 0;
    for (int n = 1; n <= TO + 8; n++) begin
      slot_ack_array = '0;
      if (!bad && v.ack_dly >= 0 && n - 1 == v.ack_dly) slot_ack_array[v.slot] = 1'b1;
      if (spur && n == 2) slot_ack_array[0] = 1'b1;
      if (busy_req && n == 4) begin mmio_cs = 1'b0; mmio_wr = 1'b0; end
      @(negedge clk);
      if (n == 1) begin
        check($sformatf("v%0d_cs_strobe", id), slot_cs_array, oh);
        check($sformatf("v%0d_wr_strobe", id), slot_mem_wr_array, v.wr ? oh : '0);
        check($sformatf("v%0d_rd_strobe", id), slot_mem_rd_array, v.rd ? oh : '0);
        if (!bad) begin
          check($sformatf("v%0d_reg_addr", id), slot_reg_addr, v.regn);
          check($sformatf("v%0d_wr_data", id), slot_wr_data, v.wdata);
        end
      end
      if (n == 2) check($sformatf("v%0d_strobe_one_cycle", id), slot_cs_array, 0);
      if (lat == 0) check($sformatf("v%0d_busy", id), mmio_busy, 1);
      if (lat != 0 && n == lat + 1) check($sformatf("v%0d_busy_drop", id), mmio_busy, 0);
      if (mmio_ready) begin
        readies++;
        if (lat == 0) lat = n;
        check($sformatf("v%0d_ready_expected", id), sb.size() > 0, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check($sformatf("v%0d_err", id), mmio_err, e.err);
          if (e.chk_rd) check($sformatf("v%0d_rd_data", id), mmio_rd_data, e.rd);
        end
      end
      @(posedge clk); #1;
    end
    slot_ack_array = '0;
    check($sformatf("v%0d_latency", id), lat, v.exp_lat);
    check($sformatf("v%0d_ready_count", id), readies, 1);
  endtask

  initial begin
    int   seen_ready;
    int   seen_strobe;
    vec_t hv;
    vecs[0] = '{1'b1, 1'b0, 2, 3,  32'h0000_00AA, 0,  32'h0,         1'b0, 1'b1, 32'h0,         2};
    vecs[1] = '{1'b0, 1'b1, 3, 1,  32'h0,         5,  32'h1234_5678, 1'b0, 1'b1, 32'h1234_5678, 7};
    vecs[2] = '{1'b0, 1'b1, 1, 4,  32'h0,         -1, 32'h0,         1'b1, 1'b1, 32'hDEAD_BEEF, 17};
    vecs[3] = '{1'b0, 1'b1, 5, 0,  32'h0,         -1, 32'h0,         1'b1, 1'b1, 32'hDEAD_BEEF, 1};
    vecs[4] = '{1'b1, 1'b1, 1, 2,  32'h0,         -1, 32'h0,         1'b1, 1'b0, 32'h0,         1};
    vecs[5] = '{1'b1, 1'b0, 0, 31, 32'h0BAD_F00D, 1,  32'h0,         1'b0, 1'b1, 32'h0,         3};
    vecs[6] = '{1'b0, 1'b1, 0, 7,  32'h0,         0,  32'hCAFE_0001, 1'b0, 1'b1, 32'hCAFE_0001, 2};
    vecs[7] = '{1'b1, 1'b0, 3, 9,  32'h5555_0000, -1, 32'h0,         1'b1, 1'b1, 32'h0,         17};
    vecs[8] = '{1'b0, 1'b1, 2, 10, 32'h0,         15, 32'h0F0F_1234, 1'b0, 1'b1, 32'h0F0F_1234, 17};
    vecs[9] = '{1'b1, 1'b0, 7, 17, 32'h1,         -1, 32'h0,         1'b1, 1'b1, 32'h0,         1};

    reset_n = 1'b0;
    mmio_cs = 1'b0; mmio_wr = 1'b0; mmio_rd = 1'b0;
    mmio_addr = '0; mmio_wr_data = '0;
    slot_rd_data_array = '0; slot_ack_array = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_outputs", {mmio_ready, mmio_err, mmio_busy, slot_cs_array, slot_mem_wr_array, slot_mem_rd_array}, 0);
    check("rst_rd_data", mmio_rd_data, 0);
    check("rst_reg_wr", {slot_reg_addr, slot_wr_data}, 0);
`ifdef MMIO_SLOT_ERR_LOG_EN
    check("rst_err_log", {err_count, err_last_addr}, 0);
`endif
    reset_n = 1'b1;

    // cs with neither direction must be ignored
    @(negedge clk);
    mmio_cs = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("no_dir_busy", mmio_busy, 0);
    check("no_dir_strobe", slot_cs_array, 0);
    mmio_cs = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_vec(i, vecs[i], 1'b0, 1'b0);
`ifdef MMIO_SLOT_ERR_LOG_EN
      if (i == 2) check("err_count_first", err_count, 1);
`endif
    end
`ifdef MMIO_SLOT_ERR_LOG_EN
    check("err_count_total", err_count, 5);
    check("err_last_addr", err_last_addr, {6'd7, 5'd17});
`endif

    // busy request and a spurious slot 0 ack during a slot 2 read
    hv = '{1'b0, 1'b1, 2, 6, 32'h0, 3, 32'h55AA_1234, 1'b0, 1'b1, 32'h55AA_1234, 5};
    run_vec(100, hv, 1'b1, 1'b1);

    // reset while waiting for an ack aborts without a ready pulse
    @(negedge clk);
    mmio_cs = 1'b1; mmio_rd = 1'b1;
    mmio_addr = '0; mmio_addr[SAW+RAW-1:0] = {6'd1, 5'd2};
    @(posedge clk); #1;
    mmio_cs = 1'b0; mmio_rd = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    seen_ready = 0;
    seen_strobe = 0;
    for (int n = 0; n < TO + 6; n++) begin
      @(negedge clk);
      if (mmio_ready) seen_ready++;
      if (slot_cs_array != 0) seen_strobe++;
    end
    check("abort_no_ready", seen_ready, 0);
    check("abort_no_strobe", seen_strobe, 0);
    check("abort_busy", mmio_busy, 0);
`ifdef MMIO_SLOT_ERR_LOG_EN
    check("abort_err_count", err_count, 0);
`endif
    run_vec(200, vecs[0], 1'b0, 1'b0);
    check("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
